// File: rtl/t9990_vram_arbiter.sv
// T9990 VRAM slot arbiter: grants each memory-access slot to the display,
// CPU or command engine and runs one RAM transaction at a time.
module t9990_vram_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int STARVE_LIM = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_mem_req,
    input  logic              i_tg_en,
    input  logic              i_dsp_req,
    input  logic              i_cpu_req,
    input  logic              i_cmd_req,
    input  logic [ADDR_W-1:0] i_dsp_addr,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic              i_cpu_we,
    input  logic              i_cmd_we,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_dsp_ack,
    output logic              o_cpu_ack,
    output logic              o_cmd_ack,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ram_valid,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic              i_ram_ack,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_overrun
);
    localparam logic       S_IDLE  = 1'b0;
    localparam logic       S_BUSY  = 1'b1;
    localparam logic [1:0] OWN_DSP = 2'd0;
    localparam logic [1:0] OWN_CPU = 2'd1;
    localparam logic [1:0] OWN_CMD = 2'd2;
    localparam logic [3:0] LIM     = 4'(STARVE_LIM);

    logic              r_state;
    logic [1:0]        r_owner;
    logic [3:0]        r_skip;

    logic              w_grant;
    logic              w_done;
    logic              w_force_cmd;
    logic [1:0]        w_owner;
    logic [ADDR_W-1:0] w_addr;
    logic              w_we;
    logic [DATA_W-1:0] w_wdata;

    // Winner selection: display first, then a starved command engine, then CPU, then command
    always_comb begin
        w_force_cmd = i_cmd_req && (r_skip == LIM);
        w_grant     = (r_state == S_IDLE) && i_mem_req && i_tg_en &&
                      (i_dsp_req || i_cpu_req || i_cmd_req);
        w_done      = (r_state == S_BUSY) && i_ram_ack;
        w_owner     = OWN_CMD;
        w_addr      = i_cmd_addr;
        w_we        = i_cmd_we;
        w_wdata     = i_cmd_wdata;
        if (i_dsp_req) begin
            w_owner = OWN_DSP;
            w_addr  = i_dsp_addr;
            w_we    = 1'b0;
            w_wdata = '0;
        end else if (!w_force_cmd && i_cpu_req) begin
            w_owner = OWN_CPU;
            w_addr  = i_cpu_addr;
            w_we    = i_cpu_we;
            w_wdata = i_cpu_wdata;
        end
    end

    // Transaction FSM: latch the winner on a grant, hold the request until RAM_ACK
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_owner     <= OWN_DSP;
            o_ram_valid <= 1'b0;
            o_ram_addr  <= '0;
            o_ram_we    <= 1'b0;
            o_ram_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_grant) begin
                    r_state     <= S_BUSY;
                    r_owner     <= w_owner;
                    o_ram_valid <= 1'b1;
                    o_ram_addr  <= w_addr;
                    o_ram_we    <= w_we;
                    o_ram_wdata <= w_wdata;
                end
                default: if (i_ram_ack) begin
                    r_state     <= S_IDLE;
                    o_ram_valid <= 1'b0;
                end
            endcase
        end
    end

    // Count CPU wins over a waiting command engine; a command win resets the count
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_skip <= '0;
        end else if (w_grant) begin
            if (w_owner == OWN_CMD)
                r_skip <= '0;
            else if (w_owner == OWN_CPU && i_cmd_req && r_skip != LIM)
                r_skip <= r_skip + 4'd1;
        end
    end

    // Completion: one-cycle ACK to the owner with the registered read data
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_dsp_ack <= 1'b0;
            o_cpu_ack <= 1'b0;
            o_cmd_ack <= 1'b0;
            o_rdata   <= '0;
        end else begin
            o_dsp_ack <= w_done && (r_owner == OWN_DSP);
            o_cpu_ack <= w_done && (r_owner == OWN_CPU);
            o_cmd_ack <= w_done && (r_owner == OWN_CMD);
            if (w_done)
                o_rdata <= i_ram_rdata;
        end
    end

    // Sticky flag for a slot strobe that lands while a transaction is in flight
    always_ff @(posedge i_clk) begin
        if (i_reset)
            o_overrun <= 1'b0;
        else if (r_state == S_BUSY && i_mem_req)
            o_overrun <= 1'b1;
    end

endmodule

// File: tb/tb_t9990_vram_arbiter.sv
// Scoreboard bench for t9990_vram_arbiter: a reference arbitration model
// predicts each grant and completion, a RAM responder drives RAM_ACK.
module tb_t9990_vram_arbiter;
    localparam int LIM = 4;

    typedef struct {
        int          own;
        logic [17:0] addr;
        logic        we;
        logic [15:0] wd;
    } txn_t;

    typedef struct {
        int          own;
        logic [15:0] rd;
        logic        we;
    } ack_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req = 1'b0, tg_en = 1'b1;
    logic        dsp_req = 1'b0, cpu_req = 1'b0, cmd_req = 1'b0;
    logic [17:0] dsp_addr = '0, cpu_addr = '0, cmd_addr = '0;
    logic        cpu_we = 1'b0, cmd_we = 1'b0;
    logic [15:0] cpu_wdata = '0, cmd_wdata = '0;
    logic        dsp_ack, cpu_ack, cmd_ack;
    logic [15:0] rdata;
    logic        ram_valid;
    logic [17:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic        ram_ack = 1'b0;
    logic [15:0] ram_rdata = '0;
    logic        overrun;

    int   n_chk = 0, n_pass = 0;
    int   m_skip = 0;
    int   own;
    txn_t txq[$];
    ack_t ackq[$];

    t9990_vram_arbiter dut (
        .i_clk(clk), .i_reset(reset), .i_mem_req(mem_req), .i_tg_en(tg_en),
        .i_dsp_req(dsp_req), .i_cpu_req(cpu_req), .i_cmd_req(cmd_req),
        .i_dsp_addr(dsp_addr), .i_cpu_addr(cpu_addr), .i_cmd_addr(cmd_addr),
        .i_cpu_we(cpu_we), .i_cmd_we(cmd_we),
        .i_cpu_wdata(cpu_wdata), .i_cmd_wdata(cmd_wdata),
        .o_dsp_ack(dsp_ack), .o_cpu_ack(cpu_ack), .o_cmd_ack(cmd_ack),
        .o_rdata(rdata), .o_ram_valid(ram_valid), .o_ram_addr(ram_addr),
        .o_ram_we(ram_we), .o_ram_wdata(ram_wdata),
        .i_ram_ack(ram_ack), .i_ram_rdata(ram_rdata), .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference arbitration: returns 0=DSP 1=CPU 2=CMD, -1 no grant
    function automatic int m_pick();
        if (dsp_req) return 0;
        if (cmd_req && m_skip == LIM) begin m_skip = 0; return 2; end
        if (cpu_req) begin
            if (cmd_req && m_skip < LIM) m_skip++;
            return 1;
        end
        if (cmd_req) begin m_skip = 0; return 2; end
        return -1;
    endfunction

    function automatic txn_t m_txn(input int w);
        txn_t t;
        t.own = w;
        case (w)
            0:       begin t.addr = dsp_addr; t.we = 1'b0;   t.wd = '0;        end
            1:       begin t.addr = cpu_addr; t.we = cpu_we; t.wd = cpu_wdata; end
            default: begin t.addr = cmd_addr; t.we = cmd_we; t.wd = cmd_wdata; end
        endcase
        return t;
    endfunction

    function automatic logic [2:0] onehot(input int w);
        logic [2:0] v;
        v = 3'b100;
        return v >> w;
    endfunction

    // One granted slot: strobe, check the RAM request, answer after lat cycles,
    // check the requester ACK. ovr pulses a slot mid-BUSY, tgd drops TG_EN mid-BUSY.
    task automatic serve(input logic [15:0] rd, input int lat, input bit ovr, input bit tgd,
                         output int w);
        txn_t t;
        ack_t a;
        w = m_pick();
        txq.push_back(m_txn(w));
        mem_req = 1'b1;
        @(negedge clk);
        mem_req = 1'b0;
        t = txq.pop_front();
        chk("ram_valid", ram_valid, 1);
        chk("ram_addr", ram_addr, t.addr);
        chk("ram_we", ram_we, t.we);
        if (t.we) chk("ram_wdata", ram_wdata, t.wd);
        if (tgd) tg_en = 1'b0;
        for (int i = 0; i < lat; i++) begin
            if (ovr && i == 0) mem_req = 1'b1;
            @(negedge clk);
            mem_req = 1'b0;
            chk("hold_valid", ram_valid, 1);
            chk("hold_addr", ram_addr, t.addr);
        end
        chk("no_early_ack", {dsp_ack, cpu_ack, cmd_ack}, 0);
        ram_ack = 1'b1;
        ram_rdata = rd;
        a.own = w; a.rd = rd; a.we = t.we;
        ackq.push_back(a);
        @(negedge clk);
        ram_ack = 1'b0;
        a = ackq.pop_front();
        chk("ack_owner", {dsp_ack, cpu_ack, cmd_ack}, onehot(a.own));
        if (!a.we) chk("rdata", rdata, a.rd);
        chk("valid_drop", ram_valid, 0);
    endtask

    task automatic idle_slot(input string tag);
        mem_req = 1'b1;
        @(negedge clk);
        mem_req = 1'b0;
        chk(tag, ram_valid, 0);
    endtask

    task automatic chk_reset_outs();
        chk("rst_valid", ram_valid, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_acks", {dsp_ack, cpu_ack, cmd_ack}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_overrun", overrun, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_reset_outs();

        // single CPU read
        cpu_req = 1'b1; cpu_addr = 18'h01234;
        serve(16'hBEEF, 1, 0, 0, own);
        chk("cpu_read_owner", own, 1);
        cpu_req = 1'b0;
        @(negedge clk);

        // display priority, CPU write, then command
        dsp_req = 1'b1; cpu_req = 1'b1; cmd_req = 1'b1;
        dsp_addr = 18'h2AAAA; cpu_addr = 18'h01111; cmd_addr = 18'h3C0DE;
        cpu_we = 1'b1; cpu_wdata = 16'hA5A5;
        serve(16'h1111, 2, 0, 0, own); dsp_req = 1'b0;
        serve(16'h2222, 0, 0, 0, own); cpu_req = 1'b0; cpu_we = 1'b0;
        serve(16'h3333, 1, 0, 0, own); cmd_req = 1'b0;
        chk("prio_last_cmd", own, 2);

        // starvation guard: CPU re-requests after each ACK
        cpu_req = 1'b1; cmd_req = 1'b1; cmd_we = 1'b1; cmd_wdata = 16'h5A5A;
        for (int s = 0; s < 9; s++) begin
            cpu_addr = 18'(s + 18'h00100);
            serve(16'(s * 16'h0101), s % 3, 0, 0, own);
        end
        cpu_req = 1'b0; cmd_req = 1'b0; cmd_we = 1'b0;
        @(negedge clk);

        // overrun: slot strobe during BUSY is not granted
        chk("ovr_clear", overrun, 0);
        cpu_req = 1'b1; cmd_req = 1'b1;
        serve(16'h4444, 3, 1, 0, own);
        chk("ovr_set", overrun, 1);
        if (own == 2) cmd_req = 1'b0; else cpu_req = 1'b0;
        serve(16'h5555, 1, 0, 0, own);
        chk("ovr_sticky", overrun, 1);
        cpu_req = 1'b0; cmd_req = 1'b0;
        @(negedge clk);

        // TG_EN gating
        tg_en = 1'b0; cpu_req = 1'b1; cpu_addr = 18'h00777;
        idle_slot("tg_off_slot0");
        idle_slot("tg_off_slot1");
        tg_en = 1'b1;
        serve(16'h6666, 2, 0, 1, own);
        chk("tg_drop_owner", own, 1);
        idle_slot("tg_off_after");
        tg_en = 1'b1;

        // reset mid-transaction
        cmd_req = 1'b1;
        own = m_pick();
        mem_req = 1'b1;
        @(negedge clk);
        mem_req = 1'b0;
        chk("mid_grant", ram_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_skip = 0;
        chk_reset_outs();
        ram_ack = 1'b1; ram_rdata = 16'hDEAD;
        @(negedge clk);
        ram_ack = 1'b0;
        chk("stale_ack0", {dsp_ack, cpu_ack, cmd_ack}, 0);
        @(negedge clk);
        chk("stale_ack1", {dsp_ack, cpu_ack, cmd_ack}, 0);

        // skip counter restarts: four CPU wins, then CMD
        for (int s = 0; s < 5; s++) begin
            serve(16'(16'h7000 + s), 1, 0, 0, own);
            chk("post_rst_order", own, (s == 4) ? 2 : 1);
        end
        cpu_req = 1'b0; cmd_req = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
